ident_scanner: RTL and testbench
================================

IDENT_SCANNER -- requirements
Module: ident_scanner

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum identifier length in characters (>=1).
REQ-002 Parameter CNT_W, default 8: width of the token counter.
REQ-003 Parameter REQ_DIGIT, default 1: 1 = identifier matches only while its last char is a digit; 0 = any identifier matches.
REQ-004 Parameter ALLOW_US, default 0: 1 = '_' is treated as a letter-class char; 0 = '_' is a delimiter.
REQ-005 Local LEN_W = clog2(MAX_LEN+1).
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset; clock and reset ports are named as the codebase does (clk, reset).
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 char  input  8  ASCII character.
REQ-010 valid  input  1  char is consumed on a rising clk edge only when valid=1.
REQ-011 out  output  1  current token matches (level).
REQ-012 tok_done  output  1  one-cycle pulse: matching token just terminated.
REQ-013 tok_len  output  LEN_W  length of the token reported by tok_done; held until the next tok_done.
REQ-014 tok_cnt  output  CNT_W  count of completed matching tokens.
REQ-015 len_err  output  1  one-cycle pulse: identifier exceeded MAX_LEN.

Function
REQ-016 Char classes SHALL be: L = 'a'-'z', 'A'-'Z', plus '_' if ALLOW_US=1; D = '0'-'9'; X = all other codes (delimiters).
REQ-017 FSM states SHALL be IDLE, ALPHA (in identifier, last char L), DIGIT (in identifier, last char D), and SKIP (in non-identifier run).
REQ-018 When valid=0, state, len and all registers SHALL hold, and tok_done and len_err SHALL be 0 on the next cycle.
REQ-019 IDLE transitions SHALL be: L -> ALPHA with len=1; D -> SKIP; X -> IDLE.
REQ-020 ALPHA/DIGIT transitions SHALL be: L -> ALPHA, len+1; D -> DIGIT, len+1; X -> IDLE.
REQ-021 SKIP transitions SHALL be: L or D -> SKIP; X -> IDLE (a token starting with a digit never matches).
REQ-022 If an L or D char in ALPHA/DIGIT would make len > MAX_LEN, the FSM SHALL go to SKIP and len_err SHALL be 1 for exactly the next cycle.
REQ-023 out SHALL be combinational from state: 1 iff state=DIGIT, or state=ALPHA with REQ_DIGIT=0.
REQ-024 On an accepted X char while out=1, tok_done SHALL be 1 for the following cycle, tok_len SHALL load len, and tok_cnt SHALL increment.
REQ-025 tok_cnt SHALL wrap modulo 2^CNT_W without a flag.
REQ-026 An X char while out=0 (including SKIP) SHALL produce no tok_done and no count change.
REQ-027 Consecutive delimiters SHALL keep the FSM in IDLE with no outputs.
REQ-028 Latency SHALL be: a char accepted on edge N is reflected in out, tok_done and len_err after edge N; tok_done and len_err are registered pulses.

Reset
REQ-029 On reset=1, asynchronously and independent of clk: state=IDLE, len=0, out=0, tok_done=0, tok_len=0, tok_cnt=0, len_err=0.
REQ-030 Reset mid-token SHALL discard the token; the next char after release is treated as the start of a new stream.

Verification (defaults unless stated, MAX_LEN=8 where noted)
REQ-031 Feed "ab1 " -> out=0,0,1,0; tok_done=1 after the ' ' edge with tok_len=3, tok_cnt=1.
REQ-032 Feed "1a2 " -> state SKIP, out stays 0, no tok_done, tok_cnt unchanged.
REQ-033 Feed "abc " with REQ_DIGIT=0 -> tok_done, tok_len=3; with REQ_DIGIT=1 -> no tok_done. Feed "a_1 " with ALLOW_US=1 -> tok_len=3; with ALLOW_US=0 -> no tok_done.
REQ-034 Feed 'a', then valid=0 for 3 cycles with char='9', then '7' with valid=1 -> out=0 during the gap, out=1 after the '7' edge, len=2.
REQ-035 MAX_LEN=8: feed "abcdefgh9 " -> len_err pulse after '9', SKIP, no tok_done; then "x1 " -> tok_len=2.
REQ-036 Assert reset between edges mid-token "ab1" -> out=0 immediately; 256 matching tokens with CNT_W=8 -> tok_cnt wraps to 0.

Source files
------------

// File: rtl/ident_scanner.sv
// Identifier scanner: classifies an ASCII stream into letter/digit/delimiter runs
// and reports identifiers that match the configured rule, with length and count.
//
// state | meaning
// IDLE  | between tokens, last char was a delimiter (or just out of reset)
// ALPHA | inside an identifier, last char was a letter-class char
// DIGIT | inside an identifier, last char was a digit
// SKIP  | inside a run that can never match (digit start or over-long)
module ident_scanner #(
   parameter int MAX_LEN   = 16,
   parameter int CNT_W     = 8,
   parameter int REQ_DIGIT = 1,
   parameter int ALLOW_US  = 0,
   localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char,
   input  logic             valid,
   output logic             out,
   output logic             tok_done,
   output logic [LEN_W-1:0] tok_len,
   output logic [CNT_W-1:0] tok_cnt,
   output logic             len_err
);

   typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, SKIP} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;
   logic             is_l, is_d;
   logic             done_nxt, err_nxt;

   assign out = (state == DIGIT) || ((state == ALPHA) && (REQ_DIGIT == 0));

   always_comb begin
      is_l = ((char >= 8'h61) && (char <= 8'h7a)) ||
             ((char >= 8'h41) && (char <= 8'h5a)) ||
             ((ALLOW_US != 0) && (char == 8'h5f));
      is_d = (char >= 8'h30) && (char <= 8'h39);
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (valid) begin
         case (state)
            IDLE: begin
               if (is_l) begin
                  state_nxt = ALPHA;
                  len_nxt   = LEN_W'(1);
               end else if (is_d) begin
                  state_nxt = SKIP;
                  len_nxt   = '0;
               end else begin
                  len_nxt   = '0;
               end
            end
            ALPHA, DIGIT: begin
               if (is_l || is_d) begin
                  // One more char would overflow: abandon the run until a delimiter
                  if (len == LEN_W'(MAX_LEN)) begin
                     state_nxt = SKIP;
                     len_nxt   = '0;
                     err_nxt   = 1'b1;
                  end else begin
                     state_nxt = is_d ? DIGIT : ALPHA;
                     len_nxt   = len + 1'b1;
                  end
               end else begin
                  state_nxt = IDLE;
                  len_nxt   = '0;
                  done_nxt  = out;
               end
            end
            SKIP: begin
               if (!(is_l || is_d)) begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               len_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         len      <= '0;
         tok_done <= 1'b0;
         len_err  <= 1'b0;
         tok_len  <= '0;
         tok_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         len      <= len_nxt;
         tok_done <= done_nxt;
         len_err  <= err_nxt;
         if (done_nxt) begin
            tok_len <= len;
            tok_cnt <= tok_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ident_scanner.sv
// Scoreboard bench for ident_scanner: two instances (MAX_LEN=8 digit-required,
// and MAX_LEN=16 any-identifier with '_' as letter) share one char stream.
module tb_ident_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] chr = 8'h00;
   logic       valid = 1'b0;

   logic       out_m, done_m, err_m;
   logic [3:0] len_m;
   logic [7:0] cnt_m;
   logic       out_a, done_a, err_a;
   logic [4:0] len_a;
   logic [7:0] cnt_a;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit err;
      int len;
      int cnt;
   } ev_t;

   ev_t q_m[$];
   ev_t q_a[$];

   always #5 clk = ~clk;

   ident_scanner #(.MAX_LEN(8)) dut_m (
      .clk(clk), .reset(reset), .char(chr), .valid(valid),
      .out(out_m), .tok_done(done_m), .tok_len(len_m), .tok_cnt(cnt_m), .len_err(err_m)
   );

   ident_scanner #(.MAX_LEN(16), .REQ_DIGIT(0), .ALLOW_US(1)) dut_a (
      .clk(clk), .reset(reset), .char(chr), .valid(valid),
      .out(out_a), .tok_done(done_a), .tok_len(len_a), .tok_cnt(cnt_a), .len_err(err_a)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_m(input bit err, input int len, input int cnt);
      ev_t e;
      e.err = err; e.len = len; e.cnt = cnt;
      q_m.push_back(e);
   endtask

   task automatic push_a(input bit err, input int len, input int cnt);
      ev_t e;
      e.err = err; e.len = len; e.cnt = cnt;
      q_a.push_back(e);
   endtask

   task automatic send(input byte c, input bit om, input bit oa);
      chr   = c;
      valid = 1'b1;
      @(posedge clk);
      #1;
      check("out_m", out_m, om);
      check("out_a", out_a, oa);
   endtask

   task automatic send_str(input string s, input string em, input string ea);
      for (int i = 0; i < s.len(); i++)
         send(s[i], em[i] == "1", ea[i] == "1");
   endtask

   task automatic cmp_ev(input string tag, input ev_t e, input logic d, input logic er,
                         input int l, input int c);
      check({tag, "_err"}, er, e.err);
      check({tag, "_done"}, d, !e.err);
      if (!e.err) begin
         check({tag, "_tok_len"}, l, e.len);
         check({tag, "_tok_cnt"}, c, e.cnt);
      end
   endtask

   // Monitor: every pulse must correspond to the next queued expectation
   always @(negedge clk) begin
      if (!reset) begin
         if (done_m || err_m) begin
            if (q_m.size() == 0) begin
               checks++; errors++;
               $display("FAIL mon_m unexpected pulse: done=%0d err=%0d, required none", done_m, err_m);
            end else cmp_ev("m", q_m.pop_front(), done_m, err_m, len_m, cnt_m);
         end
         if (done_a || err_a) begin
            if (q_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL mon_a unexpected pulse: done=%0d err=%0d, required none", done_a, err_a);
            end else cmp_ev("a", q_a.pop_front(), done_a, err_a, len_a, cnt_a);
         end
      end
   end

   initial begin
      #2;
      check("rst_out_m", out_m, 0);
      check("rst_done_m", done_m, 0);
      check("rst_len_m", len_m, 0);
      check("rst_cnt_m", cnt_m, 0);
      check("rst_err_m", err_m, 0);
      check("rst_out_a", out_a, 0);
      #10 reset = 1'b0;

      push_m(0, 3, 1); push_a(0, 3, 1);
      send_str("ab1 ", "0010", "1110");

      send_str("1a2 ", "0000", "0000");

      push_a(0, 3, 2);
      send_str("abc ", "0000", "1110");

      push_a(0, 3, 3);
      send_str("a_1 ", "0000", "1110");

      send("a", 0, 1);
      chr = "9"; valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("gap_out_m", out_m, 0);
         check("gap_out_a", out_a, 1);
      end
      push_m(0, 2, 2); push_a(0, 2, 4);
      send("7", 1, 1);
      send(" ", 0, 0);

      push_m(1, 0, 0); push_a(0, 9, 5);
      send_str("abcdefgh9 ", "0000000000", "1111111110");

      push_m(0, 2, 3); push_a(0, 2, 6);
      send_str("x1 ", "010", "110");

      send_str("  ", "00", "00");

      // Reset asserted between edges in the middle of a matching token
      send_str("ab1", "001", "111");
      #2 reset = 1'b1;
      #1;
      check("rst_mid_out_m", out_m, 0);
      check("rst_mid_out_a", out_a, 0);
      check("rst_mid_cnt_m", cnt_m, 0);
      check("rst_mid_cnt_a", cnt_a, 0);
      check("rst_mid_len_m", len_m, 0);
      @(posedge clk); #1 reset = 1'b0;
      send(" ", 0, 0);
      send_str("1 ", "00", "00");
      check("post_rst_cnt_m", cnt_m, 0);

      for (int k = 0; k < 256; k++) begin
         push_m(0, 2, (k + 1) % 256);
         push_a(0, 2, (k + 1) % 256);
         send_str("a1 ", "010", "110");
      end
      valid = 1'b0;
      check("wrap_cnt_m", cnt_m, 0);
      check("wrap_cnt_a", cnt_a, 0);

      repeat (3) @(posedge clk);
      #1;
      check("q_m_left", q_m.size(), 0);
      check("q_a_left", q_a.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
